// File: rtl/enc8b10b_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc8b10b_pkg
//  Description : Shared constants and helpers for the 8b/10b lane scheduler:
//                K-code byte values, running-disparity encodings, lane-index
//                width function and a codeword ones counter.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package enc8b10b_pkg;

  // Running disparity encodings as carried on o_rd
  localparam logic RD_MINUS = 1'b0;
  localparam logic RD_PLUS  = 1'b1;

  // Control-code bytes (HGFEDCBA) that the ROMs know about
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  // Width of a lane index; never below one bit so a vector can be declared
  function automatic int lane_idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Number of ones in a 10-bit codeword (4, 5 or 6 for legal codes)
  function automatic logic [3:0] ones10(input logic [9:0] c);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 10; i++) s = s + {3'b000, c[i]};
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/enc_lane_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : enc_lane_sched_if
//  Description : Per-lane request bus into the lane scheduler.
//  Signals     : i_req_valid [N]   per-lane request
//                i_req_data  [8N]  per-lane byte, lane n at [8n+7:8n]
//                i_req_k     [N]   per-lane control-word flag
//                o_req_ready [N]   one-hot grant back to the lanes
//  Modports    : master - lane side, slave - scheduler side
//  Revision    : 1.0 - initial release
// ============================================================================
interface enc_lane_sched_if #(
  parameter int NUM_LANES = 4
) ();
  logic [NUM_LANES-1:0]   i_req_valid;
  logic [8*NUM_LANES-1:0] i_req_data;
  logic [NUM_LANES-1:0]   i_req_k;
  logic [NUM_LANES-1:0]   o_req_ready;

  modport master (
    output i_req_valid,
    output i_req_data,
    output i_req_k,
    input  o_req_ready
  );

  modport slave (
    input  i_req_valid,
    input  i_req_data,
    input  i_req_k,
    output o_req_ready
  );
endinterface
`default_nettype wire

// File: rtl/enc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : enc_rr_arbiter
//  Description : Round-robin arbiter, one grant per cycle. Search begins at
//                an internal pointer; after a grant to lane g the pointer
//                moves to (g+1) mod N.
//  Ports       : clk, rst_n   clock, async active-low reset
//                req   [N]    request vector
//                en           1 = grants allowed
//                grant [N]    one-hot grant (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_rr_arbiter
  import enc8b10b_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);
  localparam int            PW  = lane_idx_w(N);
  localparam logic [PW:0]   C_N = (PW+1)'(N);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;
  logic [PW-1:0] w_idx;
  logic [PW:0]   w_sum;
  logic          w_found;

  // Walk the lanes starting at the pointer; the first requester wins.
  // The modulo is a single conditional subtract because ptr+i < 2N.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= C_N) w_sum = w_sum - C_N;
      w_idx = w_sum[PW-1:0];
      if (en && !w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_gidx       = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/enc_lane_sched.sv
`default_nettype none
// ============================================================================
//  Module      : enc_lane_sched
//  Description : Shares one RD-minus / RD-plus 8b/10b ROM pair between
//                NUM_LANES requesting lanes. Round-robin grant, 2-cycle
//                latency, one word per cycle, per-lane running disparity.
//  Ports       : clk, rst_n            clock, async active-low reset
//                i_en                  1 = new grants allowed
//                i_rd_init             clear every lane's RD to minus
//                req_if (slave)        per-lane valid/data/k, ready out
//                o_rom_addr/rd_en/k    ROM address, read strobe, K select
//                i_minus_/i_plus_out   ROM codewords (abcdeifghj)
//                i_minus_/i_plus_k_err ROM K-not-found flags
//                o_valid/lane/code     encoded word, one-cycle pulse
//                o_k_error             control word not in table
//                o_rd                  running disparity per lane
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_lane_sched
  import enc8b10b_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_en,
  input  logic                                i_rd_init,
  enc_lane_sched_if.slave                     req_if,
  output logic [7:0]                          o_rom_addr,
  output logic                                o_rom_rd_en,
  output logic                                o_rom_k,
  input  logic [9:0]                          i_minus_out,
  input  logic [9:0]                          i_plus_out,
  input  logic                                i_minus_k_err,
  input  logic                                i_plus_k_err,
  output logic                                o_valid,
  output logic [lane_idx_w(NUM_LANES)-1:0]    o_lane,
  output logic [9:0]                          o_code,
  output logic                                o_k_error,
  output logic [NUM_LANES-1:0]                o_rd
);
  localparam int LW = lane_idx_w(NUM_LANES);

  // ---------------------------------------------------------------- stage 1
  logic [NUM_LANES-1:0] w_grant;
  logic                 w_arb_en;
  logic                 w_any;
  logic [LW-1:0]        w_gidx;
  logic [7:0]           w_gbyte;
  logic                 w_gk;
  logic [7:0]           r_addr_hold;

  // Reset also blocks grants so the ROM strobe and ready stay low while
  // rst_n is asserted, even with requests present.
  assign w_arb_en = i_en & rst_n;

  enc_rr_arbiter #(
    .N (NUM_LANES)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_if.i_req_valid),
    .en    (w_arb_en),
    .grant (w_grant)
  );

  assign req_if.o_req_ready = w_grant;
  assign w_any              = |w_grant;

  always_comb begin
    w_gidx  = '0;
    w_gbyte = '0;
    w_gk    = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_grant[i]) begin
        w_gidx  = LW'(i);
        w_gbyte = req_if.i_req_data[8*i +: 8];
        w_gk    = req_if.i_req_k[i];
      end
    end
  end

  // Address is live in the grant cycle and parks on the last byte otherwise
  assign o_rom_addr  = w_any ? w_gbyte : r_addr_hold;
  assign o_rom_rd_en = w_any;

  // ---------------------------------------------------------------- stage 2
  logic                 r_s2_valid;
  logic [LW-1:0]        r_s2_lane;
  logic                 r_s2_k;
  logic [NUM_LANES-1:0] r_rd;
  logic [NUM_LANES-1:0] w_rd_nxt;
  logic                 w_s2_rd;
  logic [9:0]           w_code;
  logic                 w_kerr;
  logic                 w_flip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_hold <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_lane   <= '0;
      r_s2_k      <= 1'b0;
    end else begin
      r_s2_valid <= w_any;
      if (w_any) begin
        r_addr_hold <= w_gbyte;
        r_s2_lane   <= w_gidx;
        r_s2_k      <= w_gk;
      end
    end
  end

  assign o_rom_k = r_s2_k;

  // r_rd already holds the previous word's update, so back-to-back words on
  // one lane chain correctly without a bubble.
  assign w_s2_rd = r_rd[r_s2_lane];
  assign w_code  = (w_s2_rd == RD_PLUS) ? i_plus_out : i_minus_out;
  assign w_kerr  = ((w_s2_rd == RD_PLUS) ? i_plus_k_err : i_minus_k_err) & r_s2_k;
  assign w_flip  = (ones10(w_code) != 4'd5);

  always_comb begin
    w_rd_nxt = r_rd;
    if (r_s2_valid && !w_kerr && w_flip) begin
      w_rd_nxt[r_s2_lane] = ~r_rd[r_s2_lane];
    end
    // Clear has priority over a same-cycle update
    if (i_rd_init) begin
      w_rd_nxt = {NUM_LANES{RD_MINUS}};
    end
  end

  // ---------------------------------------------------------------- output
  logic          r_valid;
  logic [LW-1:0] r_lane;
  logic [9:0]    r_code;
  logic          r_kerr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= {NUM_LANES{RD_MINUS}};
      r_valid <= 1'b0;
      r_lane  <= '0;
      r_code  <= '0;
      r_kerr  <= 1'b0;
    end else begin
      r_rd    <= w_rd_nxt;
      r_valid <= r_s2_valid;
      r_kerr  <= r_s2_valid & w_kerr;
      if (r_s2_valid) begin
        r_lane <= r_s2_lane;
        r_code <= w_kerr ? 10'd0 : w_code;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_lane    = r_lane;
  assign o_code    = r_code;
  assign o_k_error = r_kerr;
  assign o_rd      = r_rd;

endmodule
`default_nettype wire

// File: doc/enc_lane_sched.md
ENC_LANE_SCHED -- requirements
Module: enc_lane_sched

Interface
REQ-001 Parameter: NUM_LANES, 4, number of requesting lanes sharing one RD-minus/RD-plus ROM pair (2..8).
REQ-002 clk  input  1  clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_en  input  1  1 = grants allowed; 0 = no new grants, in-flight words complete.
REQ-005 i_rd_init  input  1  synchronous clear of every lane's running disparity to RD-minus.
REQ-006 i_req_valid  input  NUM_LANES  per-lane request.
REQ-007 i_req_data  input  8*NUM_LANES  per-lane byte HGFEDCBA; lane n at bits [8n+7:8n].
REQ-008 i_req_k  input  NUM_LANES  per-lane 1 = control word, 0 = data word.
REQ-009 o_req_ready  output  NUM_LANES  one-hot grant; a request is consumed when valid and ready are both 1.
REQ-010 o_rom_addr  output  8  byte driven to both ROMs.
REQ-011 o_rom_rd_en  output  1  ROM read strobe, both ROMs.
REQ-012 o_rom_k  output  1  K select to both ROMs; held for the ROM-output cycle.
REQ-013 i_minus_out / i_plus_out  input  10 each  ROM codewords abcdeifghj, valid one cycle after o_rom_rd_en.
REQ-014 i_minus_k_err / i_plus_k_err  input  1 each  ROM K-not-found flags.
REQ-015 o_valid  output  1  encoded word valid, one-cycle pulse per word.
REQ-016 o_lane  output  clog2(NUM_LANES)  lane of the encoded word.
REQ-017 o_code  output  10  encoded word.
REQ-018 o_k_error  output  1  control word not in table.
REQ-019 o_rd  output  NUM_LANES  current running disparity per lane, 0 = minus, 1 = plus.

Function
REQ-020 Arbitration SHALL be round-robin: at most one grant per cycle, and only while i_en=1; search starts at the pointer; after a grant to lane g, pointer = (g+1) mod NUM_LANES.
REQ-021 o_req_ready SHALL be combinational from i_req_valid, i_en and the pointer; o_req_ready is 0 for every lane with valid=0.
REQ-022 Stage 1 (grant cycle): o_rom_addr = granted byte, o_rom_rd_en = 1; lane, k and a valid bit SHALL be registered into stage 2.
REQ-023 Stage 2 (next cycle): o_rom_k SHALL equal the registered k; codeword = i_plus_out if o_rd[lane]=1, else i_minus_out; k_err = matching ROM flag AND registered k.
REQ-024 RD update at the end of stage 2: a codeword with 6 ones or 4 ones flips o_rd[lane]; a codeword with 5 ones keeps it; on k_err, RD SHALL be unchanged.
REQ-025 Output register: o_valid/o_lane/o_code/o_k_error SHALL be loaded from stage 2, so latency is grant to o_valid = 2 cycles, and throughput is 1 word/cycle; o_code = 0 when o_k_error = 1.
REQ-026 Back-to-back grants to the same lane SHALL use the RD produced by the previous word, with no bubble.
REQ-027 When no grant occurs, o_rom_rd_en SHALL be 0, o_rom_addr SHALL hold its value, and o_valid SHALL be 0 two cycles later.
REQ-028 i_rd_init concurrent with a stage-2 RD update SHALL leave that lane at RD-minus (clear wins); the word itself still outputs normally.
REQ-029 i_en falling: words already in stage 1 and stage 2 SHALL complete.

Reset
REQ-030 While rst_n=0: o_valid=0, o_k_error=0, o_code=0, o_lane=0, o_rd=all 0, pointer=0, stage valid=0, o_rom_rd_en=0, o_rom_k=0, o_rom_addr=0.
REQ-031 Reset mid-operation SHALL discard in-flight words, with no o_valid after deassertion until a new grant plus 2 cycles.

Structure
REQ-032 Package enc8b10b_pkg SHALL hold the K-code byte constants, RD_MINUS/RD_PLUS encodings and the lane-index width function.
REQ-033 The round-robin grant logic SHALL be a sub-module enc_rr_arbiter (parameter N; inputs req, en; outputs grant; pointer internal). The ROMs are instantiated by the parent, not inside this block.

Verification
REQ-034 Lane0 sends K28.5 (8'hBC, k=1) twice from reset -> o_code 10'b0011111010 then 10'b1100000101; o_rd[0] goes 0->1->0.
REQ-035 Lane1 sends D0.0 (8'h00, k=0) at RD-minus -> o_code 10'b1001110100, o_rd[1] stays 0, o_valid exactly 2 cycles after the grant.
REQ-036 Lane2 sends 8'h00 with k=1 -> o_k_error=1, o_code=0, o_rd[2] unchanged.
REQ-037 All 4 lanes valid continuously -> grants 0,1,2,3,0,...; o_valid=1 every cycle; o_lane follows the grants.
REQ-038 i_rd_init pulsed in the stage-2 cycle of a lane3 K28.5 -> o_code 10'b0011111010 is emitted and o_rd[3] = 0.
REQ-039 rst_n asserted with 2 words in flight -> no o_valid after release; the next grant yields o_valid 2 cycles later at RD-minus.
